// File: rtl/dma_address_counter.sv
// Per-channel DMA address / word-count register file with CPU byte programming,
// a temporary working pair stepped by timing control, and terminal-count/EOP generation.
module dma_address_counter #(
    parameter int NUM_CH = 4,
    parameter int AW     = 16
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          prog_we,
    input  logic          prog_re,
    input  logic [2:0]    prog_sel,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out,
    input  logic          clear_ff,
    input  logic [1:0]    chan_sel,
    input  logic          load_temp,
    input  logic          incr_addr,
    input  logic          decr_addr,
    input  logic          decr_count,
    input  logic          store_back,
    input  logic          auto_init,
    output logic [AW-1:0] temp_address,
    output logic [AW-1:0] temp_count,
    output logic [1:0]    active_ch,
    output logic          tc,
    output logic          int_eop,
    output logic [1:0]    dbg_state,
    output logic          dbg_byte_ff
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TERM   = 2'd2
    } state_t;

    state_t        state;
    logic          byte_ff;
    logic [AW-1:0] base_addr [NUM_CH];
    logic [AW-1:0] base_cnt  [NUM_CH];
    logic [AW-1:0] cur_addr  [NUM_CH];
    logic [AW-1:0] cur_cnt   [NUM_CH];

    logic [1:0]    sel_ch;
    logic [AW-1:0] sel_word;
    logic [AW-1:0] step_addr;
    logic [AW-1:0] step_cnt;
    logic          step_tc;

    assign sel_ch      = prog_sel[2:1];
    assign dbg_state   = state;
    assign dbg_byte_ff = byte_ff;

    // Only the current registers are readable; the byte pointer picks low/high.
    always_comb begin
        sel_word = prog_sel[0] ? cur_cnt[sel_ch] : cur_addr[sel_ch];
        data_out = byte_ff ? sel_word[AW-1:8] : sel_word[7:0];
    end

    // Next working values if the current strobes were applied this cycle.
    always_comb begin
        step_addr = temp_address;
        if (incr_addr && !decr_addr) begin
            step_addr = temp_address + AW'(1);
        end else if (decr_addr && !incr_addr) begin
            step_addr = temp_address - AW'(1);
        end
        step_cnt = temp_count;
        step_tc  = 1'b0;
        if (decr_count) begin
            step_cnt = temp_count - AW'(1);
            step_tc  = (temp_count == '0);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            byte_ff      <= 1'b0;
            temp_address <= '0;
            temp_count   <= '0;
            active_ch    <= '0;
            tc           <= 1'b0;
            int_eop      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                base_addr[i] <= '0;
                base_cnt[i]  <= '0;
                cur_addr[i]  <= '0;
                cur_cnt[i]   <= '0;
            end
        end else begin
            int_eop <= 1'b0;

            if (clear_ff) begin
                byte_ff <= 1'b0;
            end else if (prog_we || prog_re) begin
                byte_ff <= ~byte_ff;
            end

            case (state)
                IDLE: begin
                    if (load_temp) begin
                        temp_address <= cur_addr[chan_sel];
                        temp_count   <= cur_cnt[chan_sel];
                        active_ch    <= chan_sel;
                        state        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    temp_address <= step_addr;
                    temp_count   <= step_cnt;
                    if (step_tc) begin
                        tc      <= 1'b1;
                        int_eop <= 1'b1;
                    end
                    if (store_back) begin
                        // A TC reached in this same cycle counts as leaving via TERM.
                        if (auto_init && step_tc) begin
                            cur_addr[active_ch] <= base_addr[active_ch];
                            cur_cnt[active_ch]  <= base_cnt[active_ch];
                        end else begin
                            cur_addr[active_ch] <= step_addr;
                            cur_cnt[active_ch]  <= step_cnt;
                        end
                        tc    <= 1'b0;
                        state <= IDLE;
                    end else if (step_tc) begin
                        state <= TERM;
                    end
                end
                TERM: begin
                    if (store_back) begin
                        if (auto_init) begin
                            cur_addr[active_ch] <= base_addr[active_ch];
                            cur_cnt[active_ch]  <= base_cnt[active_ch];
                        end else begin
                            cur_addr[active_ch] <= temp_address;
                            cur_cnt[active_ch]  <= temp_count;
                        end
                        tc    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the store-back so a CPU byte overrides that byte only.
            if (prog_we) begin
                if (prog_sel[0]) begin
                    if (byte_ff) begin
                        base_cnt[sel_ch][AW-1:8] <= data_in;
                        cur_cnt[sel_ch][AW-1:8]  <= data_in;
                    end else begin
                        base_cnt[sel_ch][7:0] <= data_in;
                        cur_cnt[sel_ch][7:0]  <= data_in;
                    end
                end else begin
                    if (byte_ff) begin
                        base_addr[sel_ch][AW-1:8] <= data_in;
                        cur_addr[sel_ch][AW-1:8]  <= data_in;
                    end else begin
                        base_addr[sel_ch][7:0] <= data_in;
                        cur_addr[sel_ch][7:0]  <= data_in;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_address_counter.sv
// Bench for dma_address_counter: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the register file.
module tb_dma_address_counter;

    localparam int S_IDLE = 0, S_ACTIVE = 1, S_TERM = 2;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        prog_we = 1'b0, prog_re = 1'b0, clear_ff = 1'b0;
    logic [2:0]  prog_sel = 3'd0;
    logic [7:0]  data_in = 8'd0;
    logic [7:0]  data_out;
    logic [1:0]  chan_sel = 2'd0;
    logic        load_temp = 1'b0, incr_addr = 1'b0, decr_addr = 1'b0;
    logic        decr_count = 1'b0, store_back = 1'b0, auto_init = 1'b0;
    logic [15:0] temp_address, temp_count;
    logic [1:0]  active_ch, dbg_state;
    logic        tc, int_eop, dbg_byte_ff;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Reference model state
    logic [15:0] m_base_addr[4], m_base_cnt[4], m_cur_addr[4], m_cur_cnt[4];
    logic [15:0] m_tadr, m_tcnt;
    logic [1:0]  m_ach;
    logic        m_tc, m_eop, m_bff;
    int          m_phase;

    dma_address_counter #(.NUM_CH(4), .AW(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .prog_we(prog_we), .prog_re(prog_re), .prog_sel(prog_sel),
        .data_in(data_in), .data_out(data_out), .clear_ff(clear_ff),
        .chan_sel(chan_sel), .load_temp(load_temp),
        .incr_addr(incr_addr), .decr_addr(decr_addr), .decr_count(decr_count),
        .store_back(store_back), .auto_init(auto_init),
        .temp_address(temp_address), .temp_count(temp_count),
        .active_ch(active_ch), .tc(tc), .int_eop(int_eop),
        .dbg_state(dbg_state), .dbg_byte_ff(dbg_byte_ff)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_base_addr[i] = 0; m_base_cnt[i] = 0; m_cur_addr[i] = 0; m_cur_cnt[i] = 0;
        end
        m_tadr = 0; m_tcnt = 0; m_ach = 0; m_tc = 0; m_eop = 0; m_bff = 0; m_phase = S_IDLE;
    endtask

    task automatic model_writeback();
        if (auto_init && m_phase == S_TERM) begin
            m_cur_addr[m_ach] = m_base_addr[m_ach];
            m_cur_cnt[m_ach]  = m_base_cnt[m_ach];
        end else begin
            m_cur_addr[m_ach] = m_tadr;
            m_cur_cnt[m_ach]  = m_tcnt;
        end
        m_tc = 0;
        m_phase = S_IDLE;
    endtask

    // One clock of the specification's rules, using the inputs presented now.
    task automatic model_step();
        int na, nc;
        int idx;
        m_eop = 0;
        case (m_phase)
            S_IDLE: if (load_temp) begin
                m_tadr = m_cur_addr[chan_sel]; m_tcnt = m_cur_cnt[chan_sel];
                m_ach = chan_sel; m_phase = S_ACTIVE;
            end
            S_ACTIVE: begin
                na = (int'(m_tadr) + int'(incr_addr) - int'(decr_addr)) & 32'hFFFF;
                nc = decr_count ? ((int'(m_tcnt) - 1) & 32'hFFFF) : int'(m_tcnt);
                if (decr_count && m_tcnt == 0) begin
                    m_tc = 1; m_eop = 1; m_phase = S_TERM;
                end
                m_tadr = 16'(na); m_tcnt = 16'(nc);
                if (store_back) model_writeback();
            end
            default: if (store_back) model_writeback();
        endcase
        if (prog_we) begin
            idx = int'(prog_sel[2:1]);
            if (prog_sel[0]) begin
                if (m_bff) begin m_base_cnt[idx][15:8] = data_in; m_cur_cnt[idx][15:8] = data_in; end
                else       begin m_base_cnt[idx][7:0]  = data_in; m_cur_cnt[idx][7:0]  = data_in; end
            end else begin
                if (m_bff) begin m_base_addr[idx][15:8] = data_in; m_cur_addr[idx][15:8] = data_in; end
                else       begin m_base_addr[idx][7:0]  = data_in; m_cur_addr[idx][7:0]  = data_in; end
            end
        end
        if (clear_ff) m_bff = 0;
        else if (prog_we || prog_re) m_bff = ~m_bff;
    endtask

    function automatic logic [7:0] model_dout();
        logic [15:0] w;
        w = prog_sel[0] ? m_cur_cnt[prog_sel[2:1]] : m_cur_addr[prog_sel[2:1]];
        return m_bff ? w[15:8] : w[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        prog_we = 0; prog_re = 0; clear_ff = 0; load_temp = 0;
        incr_addr = 0; decr_addr = 0; decr_count = 0; store_back = 0;
    endtask

    task automatic do_clear();
        clear_ff = 1; tick();
    endtask

    task automatic cpu_write(input logic [2:0] sel, input logic [7:0] b);
        prog_sel = sel; data_in = b; prog_we = 1; tick();
    endtask

    task automatic prog_word(input int ch, input bit is_cnt, input logic [15:0] v);
        do_clear();
        cpu_write(3'(ch * 2 + int'(is_cnt)), v[7:0]);
        cpu_write(3'(ch * 2 + int'(is_cnt)), v[15:8]);
    endtask

    task automatic cpu_read(input logic [2:0] sel, output logic [7:0] b);
        prog_sel = sel; prog_re = 1; #1; b = data_out; tick();
    endtask

    task automatic load_ch(input logic [1:0] ch);
        chan_sel = ch; load_temp = 1; tick();
    endtask

    task automatic step(input bit inc, input bit dec, input bit dcnt, input bit sb, input bit ai);
        incr_addr = inc; decr_addr = dec; decr_count = dcnt; store_back = sb; auto_init = ai; tick();
    endtask

    // Reads both bytes of a register and compares against the expected queue.
    task automatic read_word_check(input string name, input logic [2:0] sel);
        logic [7:0] got, exp;
        do_clear();
        for (int k = 0; k < 2; k++) begin
            cpu_read(sel, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s byte%0d got=%h exp=%h", name, k, got, exp);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++; if (temp_address !== 16'h0) begin errors++; $display("FAIL reset_taddr got=%h exp=0000", temp_address); end
        checks++; if (temp_count !== 16'h0) begin errors++; $display("FAIL reset_tcnt got=%h exp=0000", temp_count); end
        checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_ach got=%0d exp=0", active_ch); end
        checks++; if (tc !== 1'b0 || int_eop !== 1'b0) begin errors++; $display("FAIL reset_tc_eop got=%b%b exp=00", tc, int_eop); end
        checks++; if (dbg_state !== 2'(S_IDLE)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
        checks++; if (dbg_byte_ff !== 1'b0) begin errors++; $display("FAIL reset_bff got=%b exp=0", dbg_byte_ff); end
        checks++; if (data_out !== 8'h0) begin errors++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    endtask

    task automatic test_program();
        prog_word(2, 0, 16'h1234);
        prog_word(2, 1, 16'h0002);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        read_word_check("prog_ch2_addr", 3'd4);
        exp_q.push_back(8'h02); exp_q.push_back(8'h00);
        read_word_check("prog_ch2_cnt", 3'd5);
        checks++; if (dbg_byte_ff !== 1'b0) begin errors++; $display("FAIL prog_bff got=%b exp=0", dbg_byte_ff); end
        // clear_ff wins over a simultaneous read toggle
        prog_re = 1; clear_ff = 1; tick();
        checks++; if (dbg_byte_ff !== 1'b0) begin errors++; $display("FAIL prog_clear_prio got=%b exp=0", dbg_byte_ff); end
    endtask

    task automatic test_transfer();
        load_ch(2'd2);
        checks++; if (temp_address !== 16'h1234 || temp_count !== 16'h0002) begin
            errors++; $display("FAIL xfer_load got=%h/%h exp=1234/0002", temp_address, temp_count); end
        checks++; if (active_ch !== 2'd2 || dbg_state !== 2'(S_ACTIVE)) begin
            errors++; $display("FAIL xfer_load_ch got=%0d st=%0d exp=2 st=%0d", active_ch, dbg_state, S_ACTIVE); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0);
            checks++;
            if (tc !== (i == 2) || int_eop !== (i == 2)) begin
                errors++; $display("FAIL xfer_tc_%0d got=%b%b exp=%b%b", i, tc, int_eop, i == 2, i == 2); end
        end
        checks++; if (temp_count !== 16'hFFFF || temp_address !== 16'h1237) begin
            errors++; $display("FAIL xfer_end got=%h/%h exp=1237/FFFF", temp_address, temp_count); end
        checks++; if (dbg_state !== 2'(S_TERM)) begin errors++; $display("FAIL xfer_term got=%0d exp=%0d", dbg_state, S_TERM); end
        step(1, 0, 0, 0, 0);
        checks++; if (temp_address !== 16'h1237 || tc !== 1'b1 || int_eop !== 1'b0) begin
            errors++; $display("FAIL xfer_term_hold got=%h tc=%b eop=%b exp=1237 tc=1 eop=0", temp_address, tc, int_eop); end
    endtask

    task automatic test_store_back();
        step(0, 0, 0, 1, 0);
        checks++; if (tc !== 1'b0 || dbg_state !== 2'(S_IDLE)) begin
            errors++; $display("FAIL store_exit got tc=%b st=%0d exp tc=0 st=0", tc, dbg_state); end
        exp_q.push_back(8'h37); exp_q.push_back(8'h12);
        read_word_check("store_ch2_addr", 3'd4);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        read_word_check("store_ch2_cnt", 3'd5);
        // same transfer again, this time auto-initialising from base
        prog_word(2, 0, 16'h1234);
        prog_word(2, 1, 16'h0002);
        load_ch(2'd2);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        read_word_check("autoinit_ch2_addr", 3'd4);
        exp_q.push_back(8'h02); exp_q.push_back(8'h00);
        read_word_check("autoinit_ch2_cnt", 3'd5);
    endtask

    task automatic test_wrap();
        prog_word(0, 0, 16'hFFFF);
        load_ch(2'd0);
        step(1, 0, 0, 0, 0);
        checks++; if (temp_address !== 16'h0000) begin errors++; $display("FAIL wrap_up got=%h exp=0000", temp_address); end
        step(0, 0, 0, 1, 0);
        prog_word(1, 0, 16'h0000);
        load_ch(2'd1);
        step(0, 1, 0, 0, 0);
        checks++; if (temp_address !== 16'hFFFF) begin errors++; $display("FAIL wrap_down got=%h exp=FFFF", temp_address); end
        step(1, 1, 0, 0, 0);
        checks++; if (temp_address !== 16'hFFFF) begin errors++; $display("FAIL wrap_both got=%h exp=FFFF", temp_address); end
        step(0, 0, 0, 1, 0);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        read_word_check("wrap_ch1_addr", 3'd2);
    endtask

    task automatic test_back_to_back();
        prog_word(3, 0, 16'h1111);
        prog_word(3, 1, 16'h0105);
        load_ch(2'd3);
        step(0, 0, 1, 0, 0);
        checks++; if (temp_count !== 16'h0104) begin errors++; $display("FAIL coll_tcnt got=%h exp=0104", temp_count); end
        do_clear();
        prog_sel = 3'd7; data_in = 8'hAA; prog_we = 1; store_back = 1; auto_init = 0;
        tick();
        exp_q.push_back(8'hAA); exp_q.push_back(8'h01);
        read_word_check("coll_ch3_cnt", 3'd7);
        exp_q.push_back(8'h11); exp_q.push_back(8'h11);
        read_word_check("coll_ch3_addr", 3'd6);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        prog_word(1, 0, 16'h5555);
        prog_word(1, 1, 16'h0000);
        load_ch(2'd1);
        step(1, 0, 1, 0, 0);
        checks++; if (tc !== 1'b1 || int_eop !== 1'b1) begin
            errors++; $display("FAIL rst_pre got=%b%b exp=11", tc, int_eop); end
        RESET_N = 0;
        #1;
        checks++; if (tc !== 1'b0 || int_eop !== 1'b0) begin errors++; $display("FAIL rst_async_tc got=%b%b exp=00", tc, int_eop); end
        checks++; if (temp_address !== 16'h0 || temp_count !== 16'h0) begin
            errors++; $display("FAIL rst_async_temp got=%h/%h exp=0000/0000", temp_address, temp_count); end
        checks++; if (active_ch !== 2'd0 || dbg_state !== 2'(S_IDLE) || dbg_byte_ff !== 1'b0) begin
            errors++; $display("FAIL rst_async_ctl got ch=%0d st=%0d bff=%b exp 0/0/0", active_ch, dbg_state, dbg_byte_ff); end
        model_reset();
        #2;
        RESET_N = 1;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 2; k++) begin
                cpu_read(3'(s), got);
                checks++;
                if (got !== 8'h00) begin errors++; $display("FAIL rst_reg sel%0d byte%0d got=%h exp=00", s, k, got); end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            prog_we    = ($urandom_range(0, 9) == 0);
            prog_re    = ($urandom_range(0, 9) == 0);
            prog_sel   = 3'($urandom_range(0, 7));
            data_in    = m_bff ? (($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00)
                               : 8'($urandom_range(0, 6));
            clear_ff   = ($urandom_range(0, 7) == 0);
            chan_sel   = 2'($urandom_range(0, 3));
            load_temp  = 1'($urandom_range(0, 1));
            incr_addr  = 1'($urandom_range(0, 1));
            decr_addr  = 1'($urandom_range(0, 1));
            decr_count = 1'($urandom_range(0, 1));
            store_back = ($urandom_range(0, 11) == 0);
            auto_init  = 1'($urandom_range(0, 1));
            tick();
            checks++; if (temp_address !== m_tadr) begin errors++; $display("FAIL rnd_taddr n=%0d got=%h exp=%h", n, temp_address, m_tadr); end
            checks++; if (temp_count !== m_tcnt) begin errors++; $display("FAIL rnd_tcnt n=%0d got=%h exp=%h", n, temp_count, m_tcnt); end
            checks++; if (active_ch !== m_ach) begin errors++; $display("FAIL rnd_ach n=%0d got=%0d exp=%0d", n, active_ch, m_ach); end
            checks++; if (tc !== m_tc || int_eop !== m_eop) begin errors++; $display("FAIL rnd_tc n=%0d got=%b%b exp=%b%b", n, tc, int_eop, m_tc, m_eop); end
            checks++; if (dbg_state !== 2'(m_phase)) begin errors++; $display("FAIL rnd_state n=%0d got=%0d exp=%0d", n, dbg_state, m_phase); end
            checks++; if (data_out !== model_dout()) begin errors++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, data_out, model_dout()); end
        end
    endtask

    initial begin
        model_reset();
        RESET_N = 0;
        #12;
        RESET_N = 1;
        @(posedge CLK);
        #1;
        test_reset();
        test_program();
        test_transfer();
        test_store_back();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
